// File: rtl/snn_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snn_loader_pkg
// Brief    : Shared types for the SNN image-stream loader (FSM states, run
//            modes) and a lane-index width helper.
// Revision : 1.0 - initial release
// ============================================================================
package snn_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    START = 3'd3,
    DONE  = 3'd4
  } loader_state_e;

  typedef enum logic [1:0] {
    MODE_TRAIN    = 2'd0,
    MODE_TEST     = 2'd1,
    MODE_CLASSIFY = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  // Lane index width; a single lane still gets a 1-bit field
  function automatic int loader_ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snn_stream_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : snn_stream_loader_if
// Brief    : Image input stream and core output stream of the loader.
//            slave  = loader side, master = producer/consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface snn_stream_loader_if #(
  parameter int DATA_W = 32,
  parameter int CH_W   = 1
);
  logic [DATA_W-1:0] image_in;
  logic              valid_image;
  logic              ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic              out_last;

  modport slave (
    input  image_in, valid_image, out_ready,
    output ready, out_data, out_valid, out_ch, out_last
  );

  modport master (
    output image_in, valid_image, out_ready,
    input  ready, out_data, out_valid, out_ch, out_last
  );
endinterface
`default_nettype wire

// File: rtl/snn_stream_loader_fifo.sv
`default_nettype none
// ============================================================================
// Module   : snn_sync_fifo
// Brief    : Single-clock FIFO, power-of-2 depth. Simultaneous push and pop
//            when full is accepted and leaves the count unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module snn_sync_fifo #(
  parameter  int DATA_W     = 32,
  parameter  int FIFO_DEPTH = 8,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  // A full FIFO may still take a word when one leaves in the same cycle
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Next pointers, count and storage contents
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset flushes and zeroes the read port
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/snn_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : snn_stream_loader
// Brief    : Image-stream front end for the SNN core. Buffers image words,
//            deals them round-robin over NUM_CH lanes, latches the image
//            label, pulses start_core_img per image and raises valid_all
//            once the programmed number of images has been delivered.
//            Optional per-image checksum: define SNN_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module snn_stream_loader
  import snn_loader_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int LABEL_W       = 8,
  parameter int WORDS_PER_IMG = 196,
  parameter int FIFO_DEPTH    = 8,
  parameter int NUM_CH        = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_main,
  input  logic [1:0]         train_test_classify,
  input  logic [LABEL_W-1:0] test_label,
  input  logic [15:0]        img_count_cfg,
  snn_stream_loader_if.slave bus,
  output logic               start_core_img,
  output logic [LABEL_W-1:0] image_label,
  output logic               valid_all,
  output logic [31:0]        img_checksum
);

  localparam int CH_W   = loader_ch_width(NUM_CH);
  localparam int WCNT_W = $clog2(WORDS_PER_IMG + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(WORDS_PER_IMG - 1);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

  loader_state_e      state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [LABEL_W-1:0] label_q, label_d;
  logic [LABEL_W-1:0] image_label_q, image_label_d;
  logic [WCNT_W-1:0]  push_cnt_q, push_cnt_d;
  logic [WCNT_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               done_q, done_d;
  logic [15:0]        img_cnt_q, img_cnt_d;
  logic               valid_all_q, valid_all_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FCNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0]  fifo_rdata;
  logic               load_ready;
  logic               start_accept;
  logic               drain_done;
  logic [15:0]        cfg_eff;

  snn_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus.image_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign start_accept = (state_q == IDLE) & start_main & (train_test_classify != MODE_RSVD);
  // Last word has left the FIFO and nothing is left buffered
  assign drain_done   = (state_q == DRAIN) & (fifo_count == '0) & done_q;
  assign cfg_eff      = (img_count_cfg == 16'd0) ? 16'd1 : img_count_cfg;

  assign fifo_push     = bus.valid_image & load_ready;
  assign fifo_pop      = ~fifo_empty & bus.out_ready;
  assign bus.ready     = load_ready;
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_rdata;
  assign bus.out_ch    = ch_q;
  assign bus.out_last  = ~fifo_empty & (pop_cnt_q == LAST_IDX);
  assign image_label   = image_label_q;
  assign valid_all     = valid_all_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_accept) state_d = LOAD;
      LOAD:    if (fifo_push && push_cnt_q == LAST_IDX) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = START;
      START:   state_d = (img_cnt_q < cfg_eff) ? LOAD : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: input acceptance depends only on state and FIFO fill
  always_comb begin
    load_ready     = 1'b0;
    start_core_img = 1'b0;
    case (state_q)
      LOAD:    load_ready     = ~fifo_full;
      START:   start_core_img = 1'b1;
      default: ;
    endcase
  end

  // Word/lane/image counters, label latch and run status
  always_comb begin
    mode_d        = mode_q;
    label_d       = label_q;
    image_label_d = image_label_q;
    push_cnt_d    = push_cnt_q;
    pop_cnt_d     = pop_cnt_q;
    ch_d          = ch_q;
    done_d        = done_q;
    img_cnt_d     = img_cnt_q;
    valid_all_d   = valid_all_q;

    if (start_accept) begin
      mode_d      = mode_e'(train_test_classify);
      valid_all_d = 1'b0;
      img_cnt_d   = '0;
      push_cnt_d  = '0;
      pop_cnt_d   = '0;
      ch_d        = '0;
      done_d      = 1'b0;
    end

    if (fifo_push) begin
      if (push_cnt_q == '0) label_d = test_label;
      push_cnt_d = (push_cnt_q == LAST_IDX) ? '0 : push_cnt_q + WCNT_W'(1);
    end

    if (fifo_pop) begin
      if (pop_cnt_q == LAST_IDX) begin
        pop_cnt_d = '0;
        ch_d      = '0;
        done_d    = 1'b1;
      end else begin
        pop_cnt_d = pop_cnt_q + WCNT_W'(1);
        ch_d      = (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
      end
    end

    // Label becomes visible together with the start_core_img pulse
    if (drain_done) begin
      image_label_d = (mode_q == MODE_CLASSIFY) ? '0 : label_q;
      img_cnt_d     = img_cnt_q + 16'd1;
      done_d        = 1'b0;
    end

    if (state_q == DONE) valid_all_d = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= MODE_TRAIN;
      label_q       <= '0;
      image_label_q <= '0;
      push_cnt_q    <= '0;
      pop_cnt_q     <= '0;
      ch_q          <= '0;
      done_q        <= 1'b0;
      img_cnt_q     <= '0;
      valid_all_q   <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      label_q       <= label_d;
      image_label_q <= image_label_d;
      push_cnt_q    <= push_cnt_d;
      pop_cnt_q     <= pop_cnt_d;
      ch_q          <= ch_d;
      done_q        <= done_d;
      img_cnt_q     <= img_cnt_d;
      valid_all_q   <= valid_all_d;
    end
  end

`ifdef SNN_LOADER_CHECKSUM_EN
  logic [31:0] pop_word32;
  logic [31:0] acc_q, acc_d;
  logic [31:0] checksum_q, checksum_d;

  if (DATA_W >= 32) begin : g_word_trunc
    assign pop_word32 = fifo_rdata[31:0];
  end else begin : g_word_zext
    assign pop_word32 = {{(32 - DATA_W){1'b0}}, fifo_rdata};
  end

  assign img_checksum = checksum_q;

  // Wrapping sum of delivered words, published and cleared per image
  always_comb begin
    acc_d      = acc_q;
    checksum_d = checksum_q;
    if (fifo_pop) acc_d = acc_q + pop_word32;
    if (drain_done) begin
      checksum_d = acc_q;
      acc_d      = '0;
    end
  end

  // Checksum registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      checksum_q <= '0;
    end else begin
      acc_q      <= acc_d;
      checksum_q <= checksum_d;
    end
  end
`else
  assign img_checksum = 32'd0;
`endif

endmodule
`default_nettype wire
